// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - request/response and memory-port bundle for mem_ctrl
interface mem_ctrl_if;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall_o;
  logic        done_o;
  logic        addr_err_o;
  logic [31:0] rdata_o;
  logic        mem_ce;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_byte_slct;
  logic [31:0] mem_data_o;
  logic [31:0] mem_data_i;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, mem_data_i,
    output stall_o, done_o, addr_err_o, rdata_o,
    output mem_ce, mem_we, mem_addr, mem_byte_slct, mem_data_o
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, mem_data_i,
    input  stall_o, done_o, addr_err_o, rdata_o,
    input  mem_ce, mem_we, mem_addr, mem_byte_slct, mem_data_o
  );
endinterface

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - MEM-stage load/store controller with fixed-latency big-endian memory access
module mem_ctrl #(
  parameter int WAIT_CYCLES = 1
) (
  input logic       clk,
  input logic       rst,
  mem_ctrl_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [2:0]  r_op;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_misalign;
  logic        w_accept;
  logic        w_last;
  logic        w_is_store;
  logic [3:0]  w_slct;
  logic [31:0] w_store_data;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  always_comb begin
    w_misalign = 1'b0;
    case (bus.req_op)
      3'b010, 3'b011, 3'b110: w_misalign = bus.req_addr[0];
      3'b100, 3'b111:         w_misalign = |bus.req_addr[1:0];
      default:                w_misalign = 1'b0;
    endcase
  end

  assign w_accept = (r_state == S_IDLE) && bus.req_valid;
  assign w_last   = (r_cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op    <= bus.req_op;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_err   <= w_misalign;
        r_cnt   <= '0;
        r_rdata <= '0;
      end else if (r_state == S_ACCESS) begin
        r_cnt <= r_cnt + 4'd1;
        if (w_last) r_rdata <= bus.mem_data_i;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.req_valid) w_next = w_misalign ? S_RESP : S_ACCESS;
      S_ACCESS: if (w_last) w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Lane steering: byte offset 0 lives in bits [31:24].
  always_comb begin
    w_is_store   = r_op[2] & (r_op[1] | r_op[0]);
    w_slct       = 4'b1111;
    w_store_data = r_wdata;
    w_byte       = 8'h00;
    case (r_op)
      3'b000, 3'b001, 3'b101: w_slct = 4'b1000 >> r_addr[1:0];
      3'b010, 3'b011, 3'b110: w_slct = r_addr[1] ? 4'b0011 : 4'b1100;
      default:                w_slct = 4'b1111;
    endcase
    case (r_op)
      3'b101:  w_store_data = {4{r_wdata[7:0]}};
      3'b110:  w_store_data = {2{r_wdata[15:0]}};
      default: w_store_data = r_wdata;
    endcase
    case (r_addr[1:0])
      2'd0:    w_byte = r_rdata[31:24];
      2'd1:    w_byte = r_rdata[23:16];
      2'd2:    w_byte = r_rdata[15:8];
      default: w_byte = r_rdata[7:0];
    endcase
    w_half = r_addr[1] ? r_rdata[15:0] : r_rdata[31:16];
    case (r_op)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {24'h0, w_byte};
      3'b010:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b011:  w_load_data = {16'h0, w_half};
      3'b100:  w_load_data = r_rdata;
      default: w_load_data = 32'h0;
    endcase
  end

  always_comb begin
    bus.stall_o       = (r_state == S_ACCESS) || ((r_state == S_IDLE) && bus.req_valid);
    bus.done_o        = 1'b0;
    bus.addr_err_o    = 1'b0;
    bus.rdata_o       = 32'h0;
    bus.mem_ce        = 1'b0;
    bus.mem_we        = 1'b0;
    bus.mem_addr      = 32'h0;
    bus.mem_byte_slct = 4'b0000;
    bus.mem_data_o    = 32'h0;
    case (r_state)
      S_ACCESS: begin
        bus.mem_ce        = 1'b1;
        bus.mem_we        = w_is_store;
        bus.mem_addr      = {r_addr[31:2], 2'b00};
        bus.mem_byte_slct = w_is_store ? w_slct : 4'b0000;
        bus.mem_data_o    = w_is_store ? w_store_data : 32'h0;
      end
      S_RESP: begin
        bus.done_o     = 1'b1;
        bus.addr_err_o = r_err;
        bus.rdata_o    = (r_err || w_is_store) ? 32'h0 : w_load_data;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - scoreboard bench for mem_ctrl with WAIT_CYCLES=2
module tb_mem_ctrl;
  localparam int W = 2;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  slct;
    logic [31:0] data;
  } acc_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          done_cyc;
    logic        has_acc;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_ctrl_if bus();

  mem_ctrl #(.WAIT_CYCLES(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_mis  = 0;
  int   ce_cnt = 0;
  acc_t aq[$];
  rsp_t rq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : mon
    rsp_t r;
    if (!rst) begin
      if (bus.mem_ce) begin
        ce_cnt++;
        if (aq.size() == 0) begin
          n_vec++; n_mis++;
          $display("FAIL unexp_ce: mem_ce=1 with no access pending, required 0 (cycle %0d)", cyc);
        end else begin
          chk("acc_we",    32'(bus.mem_we),        32'(aq[0].we));
          chk("acc_addr",  bus.mem_addr,           aq[0].addr);
          chk("acc_slct",  32'(bus.mem_byte_slct), 32'(aq[0].slct));
          chk("acc_data",  bus.mem_data_o,         aq[0].data);
          chk("acc_stall", 32'(bus.stall_o),       32'd1);
        end
      end
      if (bus.done_o) begin
        if (rq.size() == 0) begin
          n_vec++; n_mis++;
          $display("FAIL unexp_done: done_o=1 with no request pending, required 0 (cycle %0d)", cyc);
        end else begin
          r = rq.pop_front();
          chk("rsp_err",     32'(bus.addr_err_o), 32'(r.err));
          chk("rsp_rdata",   bus.rdata_o,         r.rdata);
          chk("rsp_latency", 32'(cyc),            32'(r.done_cyc));
          chk("rsp_stall",   32'(bus.stall_o),    32'd0);
          chk("rsp_ce_idle", {bus.mem_ce, bus.mem_we, bus.mem_byte_slct, 26'h0}, 32'h0);
          chk("rsp_mem_out", bus.mem_addr | bus.mem_data_o, 32'h0);
          chk("ce_cycles",   32'(ce_cnt),         r.has_acc ? 32'(W) : 32'd0);
          if (r.has_acc && aq.size() > 0) void'(aq.pop_front());
        end
        ce_cnt = 0;
      end
    end
  end

  task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] mw, input logic err, input logic [31:0] rd,
                        input logic [3:0] slct, input logic [31:0] md);
    rsp_t r;
    acc_t a;
    bit   seen;
    bus.mem_data_i = mw;
    bus.req_op     = op;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    bus.req_valid  = 1'b1;
    r.err      = err;
    r.rdata    = rd;
    r.has_acc  = !err;
    r.done_cyc = cyc + 1 + (err ? 0 : W);
    rq.push_back(r);
    if (!err) begin
      a.we   = (op >= 3'd5);
      a.addr = {addr[31:2], 2'b00};
      a.slct = slct;
      a.data = md;
      aq.push_back(a);
    end
    @(negedge clk);
    chk("stall_req", 32'(bus.stall_o), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = bus.done_o;
    end
    if (!seen) begin
      n_vec++; n_mis++;
      $display("FAIL done_timeout: no done_o for op %0d addr %h within 40 cycles", op, addr);
    end
    // req_valid stays high through RESP; dropped only after the RESP->IDLE edge
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_op    = 3'd0;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    @(posedge clk); #1;
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_op     = 3'd0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.mem_data_i = 32'h0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_done",  32'(bus.done_o),        32'd0);
    chk("rst_stall", 32'(bus.stall_o),       32'd0);
    chk("rst_err",   32'(bus.addr_err_o),    32'd0);
    chk("rst_rdata", bus.rdata_o,            32'h0);
    chk("rst_ce",    32'(bus.mem_ce),        32'd0);
    chk("rst_we",    32'(bus.mem_we),        32'd0);
    chk("rst_addr",  bus.mem_addr,           32'h0);
    chk("rst_slct",  32'(bus.mem_byte_slct), 32'd0);
    chk("rst_wdata", bus.mem_data_o,         32'h0);
    @(posedge clk); #1;

    // stores: op, addr, wdata, mem word, err, rdata, slct, mem_data_o
    do_req(3'd7, 32'h50, 32'h12345678, 32'hFFFFFFFF, 1'b0, 32'h0, 4'b1111, 32'h12345678);
    do_req(3'd5, 32'h53, 32'h000000AB, 32'hFFFFFFFF, 1'b0, 32'h0, 4'b0001, 32'hABABABAB);
    do_req(3'd5, 32'h50, 32'h00000066, 32'hFFFFFFFF, 1'b0, 32'h0, 4'b1000, 32'h66666666);
    do_req(3'd6, 32'h52, 32'h0000BEEF, 32'hFFFFFFFF, 1'b0, 32'h0, 4'b0011, 32'hBEEFBEEF);
    do_req(3'd6, 32'h50, 32'h1111CAFE, 32'hFFFFFFFF, 1'b0, 32'h0, 4'b1100, 32'hCAFECAFE);
    // loads
    do_req(3'd0, 32'h51, 32'hFFFFFFFF, 32'h1280FF34, 1'b0, 32'hFFFFFF80, 4'b0000, 32'h0);
    do_req(3'd1, 32'h51, 32'hFFFFFFFF, 32'h1280FF34, 1'b0, 32'h00000080, 4'b0000, 32'h0);
    do_req(3'd1, 32'h53, 32'hFFFFFFFF, 32'h1280FF34, 1'b0, 32'h00000034, 4'b0000, 32'h0);
    do_req(3'd0, 32'h50, 32'hFFFFFFFF, 32'h1280FF34, 1'b0, 32'h00000012, 4'b0000, 32'h0);
    do_req(3'd2, 32'h52, 32'hFFFFFFFF, 32'h1234F00D, 1'b0, 32'hFFFFF00D, 4'b0000, 32'h0);
    do_req(3'd3, 32'h52, 32'hFFFFFFFF, 32'h1234F00D, 1'b0, 32'h0000F00D, 4'b0000, 32'h0);
    do_req(3'd4, 32'h50, 32'hFFFFFFFF, 32'h1234F00D, 1'b0, 32'h1234F00D, 4'b0000, 32'h0);
    do_req(3'd2, 32'h50, 32'hFFFFFFFF, 32'h1234F00D, 1'b0, 32'h00001234, 4'b0000, 32'h0);
    do_req(3'd2, 32'h54, 32'hFFFFFFFF, 32'h80010000, 1'b0, 32'hFFFF8001, 4'b0000, 32'h0);
    do_req(3'd3, 32'h54, 32'hFFFFFFFF, 32'h80010000, 1'b0, 32'h00008001, 4'b0000, 32'h0);
    // misaligned
    do_req(3'd4, 32'h42, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h0, 4'b0000, 32'h0);
    do_req(3'd2, 32'h41, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h0, 4'b0000, 32'h0);
    do_req(3'd7, 32'h52, 32'h55555555, 32'hFFFFFFFF, 1'b1, 32'h0, 4'b0000, 32'h0);
    do_req(3'd6, 32'h53, 32'h0000AAAA, 32'hFFFFFFFF, 1'b1, 32'h0, 4'b0000, 32'h0);

    // reset one cycle into a store access
    begin : abort_seq
      acc_t a;
      a.we = 1'b1; a.addr = 32'h60; a.slct = 4'b1111; a.data = 32'hDEADBEEF;
      aq.push_back(a);
      bus.req_op    = 3'd7;
      bus.req_addr  = 32'h60;
      bus.req_wdata = 32'hDEADBEEF;
      bus.req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("abort_we_pre", 32'(bus.mem_we), 32'd1);
      #1;
      rst = 1'b1;
      bus.req_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_we",    32'(bus.mem_we),  32'd0);
      chk("abort_ce",    32'(bus.mem_ce),  32'd0);
      chk("abort_done",  32'(bus.done_o),  32'd0);
      chk("abort_stall", 32'(bus.stall_o), 32'd0);
      aq.delete();
      ce_cnt = 0;
      repeat (6) @(posedge clk);
      #1;
    end

    do_req(3'd4, 32'h7C, 32'hFFFFFFFF, 32'hA5A55A5A, 1'b0, 32'hA5A55A5A, 4'b0000, 32'h0);

    repeat (3) @(posedge clk);
    chk("rq_drained", 32'(rq.size()), 32'd0);
    chk("aq_drained", 32'(aq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, required completion before 200000");
    $fatal(1);
  end
endmodule
